// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic-array loader front end.
package sys_array_pkg;

  typedef enum logic [2:0] {
    LoadW,
    LoadA,
    Params,
    Start,
    Wait,
    Done
  } loader_state_e;

  // Element index wide enough for the larger of the two matrices.
  function automatic int unsigned idx_w(input int unsigned w_elems, input int unsigned a_elems);
    int unsigned m;
    m = (w_elems > a_elems) ? w_elems : a_elems;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sys_array_matrix_buf.sv
// Register buffer for one matrix, written one element at a time in row-major order.
module sys_array_matrix_buf #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 2,
  parameter int unsigned COLS       = 5,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            wr_en,
  input  logic [IDX_W-1:0]                wr_idx,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  output logic [ROWS*COLS*DATA_WIDTH-1:0] mat
);

  localparam int unsigned N = ROWS * COLS;

  logic [DATA_WIDTH-1:0] mem_q [N];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (wr_idx == IDX_W'(i)) mem_q[i] <= wr_data;
      end
    end
  end

  // Element [0][0] sits in the most significant slot of the packed output.
  always_comb begin
    mat = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mat[(N-1-i)*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
    end
  end

endmodule

// File: rtl/sys_array_loader.sv
// Streams W and A into register buffers and sequences the fetcher (params, start, drain, done).
module sys_array_loader
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_W_W  = 2,
  parameter int unsigned ARRAY_W_L  = 5,
  parameter int unsigned ARRAY_A_W  = 5,
  parameter int unsigned ARRAY_A_L  = 2,
  parameter int unsigned DRAIN_CYC  = 16
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        in_valid,
  input  logic [DATA_WIDTH-1:0]                       in_data,
  output logic                                        in_ready,
  input  logic                                        keep_w,
  input  logic                                        fetch_ready,
  output logic                                        load_params,
  output logic                                        start_comp,
  output logic [ARRAY_W_W*ARRAY_W_L*DATA_WIDTH-1:0]   input_data_w,
  output logic [ARRAY_A_W*ARRAY_A_L*DATA_WIDTH-1:0]   input_data_b,
  output logic                                        busy,
  output logic                                        done
);

  localparam int unsigned WN   = ARRAY_W_W * ARRAY_W_L;
  localparam int unsigned AN   = ARRAY_A_W * ARRAY_A_L;
  localparam int unsigned IdxW = idx_w(WN, AN);
  localparam int unsigned CntW = $clog2(DRAIN_CYC + 1);

  loader_state_e   state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] wait_q, wait_d, wait_inc;
  logic            reused_q, reused_d;
  logic            busy_q, busy_d;
  logic            run_q;
  logic            xfer;

  // run_q keeps in_ready low while reset is held and for the release cycle.
  assign in_ready = run_q & ((state_q == LoadW) | (state_q == LoadA));
  assign xfer     = in_valid & in_ready;
  assign busy     = busy_q;
  assign wait_inc = (wait_q == CntW'(DRAIN_CYC)) ? wait_q : wait_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    reused_d    = reused_q;
    busy_d      = busy_q;
    load_params = 1'b0;
    start_comp  = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      LoadW: begin
        if (xfer) begin
          busy_d = 1'b1;
          if (idx_q == IdxW'(WN - 1)) begin
            idx_d   = '0;
            state_d = LoadA;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      LoadA: begin
        if (xfer) begin
          busy_d = 1'b1;
          if (idx_q == IdxW'(AN - 1)) begin
            idx_d   = '0;
            state_d = reused_q ? Start : Params;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      Params: begin
        load_params = 1'b1;
        state_d     = Start;
      end
      Start: begin
        start_comp = 1'b1;
        wait_d     = '0;
        state_d    = Wait;
      end
      // Exit on the edge where the count reaches DRAIN_CYC, giving DRAIN_CYC cycles in Wait.
      Wait: begin
        wait_d = wait_inc;
        if (wait_inc == CntW'(DRAIN_CYC) && fetch_ready) state_d = Done;
      end
      Done: begin
        done     = 1'b1;
        busy_d   = 1'b0;
        idx_d    = '0;
        reused_d = keep_w;
        state_d  = keep_w ? LoadA : LoadW;
      end
      default: state_d = LoadW;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= LoadW;
      idx_q    <= '0;
      wait_q   <= '0;
      reused_q <= 1'b0;
      busy_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      reused_q <= reused_d;
      busy_q   <= busy_d;
      run_q    <= 1'b1;
    end
  end

  sys_array_matrix_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .ROWS      (ARRAY_W_W),
    .COLS      (ARRAY_W_L),
    .IDX_W     (IdxW)
  ) u_buf_w (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (xfer && (state_q == LoadW)),
    .wr_idx (idx_q),
    .wr_data(in_data),
    .mat    (input_data_w)
  );

  sys_array_matrix_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .ROWS      (ARRAY_A_W),
    .COLS      (ARRAY_A_L),
    .IDX_W     (IdxW)
  ) u_buf_a (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (xfer && (state_q == LoadA)),
    .wr_idx (idx_q),
    .wr_data(in_data),
    .mat    (input_data_b)
  );

endmodule

// File: tb/tb_sys_array_loader.sv
// Directed bench for sys_array_loader: full job, stall, W reuse, late fetch_ready, mid-job reset.
module tb_sys_array_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        keep_w = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        in_ready, load_params, start_comp, busy, done;
  logic [79:0] input_data_w, input_data_b;

  sys_array_loader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .keep_w      (keep_w),
    .fetch_ready (fetch_ready),
    .load_params (load_params),
    .start_comp  (start_comp),
    .input_data_w(input_data_w),
    .input_data_b(input_data_b),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0, xfer_cyc = 0;
  int lp_n = 0, lp_cyc = 0, sc_n = 0, sc_cyc = 0, done_n = 0, done_cyc = 0;
  int rdy_viol = 0;
  bit in_wait = 1'b0;

  // Event log sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) in_wait = 1'b0;
    if (in_valid && in_ready) xfer_cyc = cyc;
    if (load_params) begin lp_n++; lp_cyc = cyc; end
    if (start_comp) begin
      sc_n++; sc_cyc = cyc; in_wait = 1'b1;
    end else if (in_wait && in_ready) begin
      rdy_viol++;
    end
    if (done) begin done_n++; done_cyc = cyc; in_wait = 1'b0; end
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] mat(input int base);
    logic [79:0] m;
    m = '0;
    for (int k = 0; k < 10; k++) m[(9-k)*8 +: 8] = 8'(base + k);
    return m;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the element transferred.
  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 80'(n), 80'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int base, input int count, input int stall_at);
    for (int i = 0; i < count; i++) begin
      if (i == stall_at) begin
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      send(8'(base + i));
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_n == prev && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_n == prev) check("done_timeout", 80'(done_n), 80'(prev + 1));
  endtask

  task automatic wait_start(input int target);
    int n;
    n = 0;
    while (sc_n < target && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sc_n < target) check("start_timeout", 80'(sc_n), 80'(target));
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {in_ready, load_params, start_comp, done, busy}, 80'(0));
    check("rst_w", input_data_w, 80'(0));
    check("rst_b", input_data_b, 80'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_rst", in_ready, 80'(1));

    // Full job, fresh W
    fetch_ready = 1'b1;
    keep_w = 1'b0;
    stream(1, 20, -1);
    check("busy_job", busy, 80'(1));
    check("lp_now", load_params, 80'(1));
    wait_done(0);
    check("busy_after_done", busy, 80'(0));
    check("full_w", input_data_w, mat(1));
    check("full_b", input_data_b, mat(11));
    check("w00", input_data_w[79:72], 80'(1));
    check("w14", input_data_w[7:0], 80'(10));
    check("b41", input_data_b[7:0], 80'(20));
    check("lp_count", 80'(lp_n), 80'(1));
    check("lp_lat", 80'(lp_cyc), 80'(xfer_cyc + 1));
    check("sc_lat", 80'(sc_cyc), 80'(lp_cyc + 1));
    check("done_lat", 80'(done_cyc), 80'(sc_cyc + 17));

    // Stall mid-A, then keep W
    keep_w = 1'b1;
    stream(1, 20, 13);
    wait_done(1);
    keep_w = 1'b0;
    check("stall_w", input_data_w, mat(1));
    check("stall_b", input_data_b, mat(11));
    check("stall_lp_count", 80'(lp_n), 80'(2));

    // Reuse: A only
    stream(21, 10, -1);
    check("reuse_sc_now", start_comp, 80'(1));
    wait_done(2);
    check("reuse_lp_count", 80'(lp_n), 80'(2));
    check("reuse_sc_lat", 80'(sc_cyc), 80'(xfer_cyc + 1));
    check("reuse_w", input_data_w, mat(1));
    check("reuse_b", input_data_b, mat(21));
    check("reuse_done_lat", 80'(done_cyc), 80'(sc_cyc + 17));

    // Late fetch_ready
    fetch_ready = 1'b0;
    rdy_viol = 0;
    stream(31, 20, -1);
    wait_start(4);
    repeat (24) @(posedge clk);
    #1;
    check("late_no_early_done", 80'(done_n), 80'(3));
    fetch_ready = 1'b1;
    wait_done(3);
    check("late_done_lat", 80'(done_cyc), 80'(sc_cyc + 26));
    check("late_rdy_low", 80'(rdy_viol), 80'(0));
    check("late_w", input_data_w, mat(31));
    check("late_b", input_data_b, mat(41));

    // Reset mid-Wait
    stream(1, 20, -1);
    wait_start(5);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_ctrl", {in_ready, load_params, start_comp, done, busy}, 80'(0));
    check("midrst_w", input_data_w, 80'(0));
    check("midrst_b", input_data_b, 80'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rdy", in_ready, 80'(1));
    repeat (30) @(posedge clk);
    #1;
    check("midrst_no_done", 80'(done_n), 80'(4));
    send(8'h55);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_first_w", input_data_w, {8'h55, 72'h0});
    check("midrst_b_clear", input_data_b, 80'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
